// File: rtl/deser_pkg.sv
// Shared definitions for deserializer_flex.
// Provides the bit-order encoding and the helper that maps the running bit
// count of a word to the bit position that receives the next serial bit.
package deser_pkg;

  typedef enum logic {
    BIT_ORDER_LSB = 1'b0,
    BIT_ORDER_MSB = 1'b1
  } bit_order_e;

  // Position of the cnt-th received bit inside a width-bit word.
  // MSB-first fills from the top down, LSB-first from the bottom up, so
  // partial words end up left- or right-aligned with no extra shifting.
  function automatic int insert_idx(input bit_order_e order,
                                    input int cnt,
                                    input int width);
    int idx;
    if (order == BIT_ORDER_MSB) begin
      idx = width - 1 - cnt;
    end else begin
      idx = cnt;
    end
    return idx;
  endfunction

endpackage

// File: rtl/deserializer_flex.sv
// deserializer_flex: collects serial bits into WIDTH-bit words.
//
// Ports:
//   clk_i            system clock, all logic on posedge
//   srst_i           synchronous reset, active-high
//   data_i           serial data bit, sampled when data_val_i=1
//   data_val_i       qualifies data_i
//   msb_first_i      bit order for the word being started (1=MSB-first)
//   flush_i          emit the accumulated partial word
//   deser_data_o     assembled word (holds last emitted value)
//   deser_mod_o      number of valid bits in deser_data_o
//   deser_data_val_o one-cycle pulse, deser_data_o/deser_mod_o valid
//   busy_o           1 while a word is partially collected
module deserializer_flex
  import deser_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             msb_first_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic [CNT_W-1:0] deser_mod_o,
  output logic             deser_data_val_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] word_r;
  bit_order_e       order_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] mod_r;
  logic             val_r;
  logic             busy_r;

  bit_order_e       order_s;
  int               idx_s;
  logic [WIDTH-1:0] word_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             emit_s;
  logic [CNT_W-1:0] emit_mod_s;

  // Next-state of the word builder: bit insertion, counter, emit decision.
  always_comb begin
    // The first bit of a word uses the live order input; afterwards the
    // latched order applies so mid-word changes are ignored.
    if (cnt_r == '0) begin
      order_s = bit_order_e'(msb_first_i);
      word_s  = '0;  // fresh word: unreceived positions read as zero
    end else begin
      order_s = order_r;
      word_s  = word_r;
    end
    idx_s      = insert_idx(order_s, int'(cnt_r), WIDTH);
    cnt_nxt_s  = cnt_r;
    emit_s     = 1'b0;
    emit_mod_s = cnt_r;

    if (data_val_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i == idx_s) begin
          word_s[i] = data_i;
        end else begin
          word_s[i] = word_s[i];
        end
      end
      // Accepting the last bit and flushing together yields one full word.
      if (cnt_r == CNT_W'(WIDTH - 1) || flush_i) begin
        emit_s     = 1'b1;
        emit_mod_s = cnt_r + CNT_W'(1);
        cnt_nxt_s  = '0;
      end else begin
        cnt_nxt_s  = cnt_r + CNT_W'(1);
      end
    end else if (flush_i && (cnt_r != '0)) begin
      emit_s     = 1'b1;
      emit_mod_s = cnt_r;
      cnt_nxt_s  = '0;
    end else begin
      cnt_nxt_s  = cnt_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_r   <= '0;
      word_r  <= '0;
      order_r <= BIT_ORDER_LSB;
      data_r  <= '0;
      mod_r   <= '0;
      val_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      word_r  <= word_s;
      order_r <= order_s;
      val_r   <= emit_s;
      busy_r  <= (cnt_nxt_s != '0);
      if (emit_s) begin
        data_r <= word_s;
        mod_r  <= emit_mod_s;
      end else begin
        data_r <= data_r;
        mod_r  <= mod_r;
      end
    end
  end

  assign deser_data_o     = data_r;
  assign deser_mod_o      = mod_r;
  assign deser_data_val_o = val_r;
  assign busy_o           = busy_r;

endmodule

// File: tb/tb_deserializer_flex.sv
// Directed self-checking bench for deserializer_flex at WIDTH 16, 8 and 32.
// Each instance has its own data_val; other inputs are shared. Instances
// that receive no valid bits stay idle, so shared flush/order do nothing.
module tb_deserializer_flex;
  import deser_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, data, msb, flush, val16, val8, val32;

  logic [15:0] d16; logic [4:0] m16; logic v16, b16;
  logic [7:0]  d8;  logic [3:0] m8;  logic v8,  b8;
  logic [31:0] d32; logic [5:0] m32; logic v32, b32;

  int checks = 0;
  int errors = 0;

  deserializer_flex #(.WIDTH(16)) dut16 (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_val_i(val16),
    .msb_first_i(msb), .flush_i(flush), .deser_data_o(d16),
    .deser_mod_o(m16), .deser_data_val_o(v16), .busy_o(b16));

  deserializer_flex #(.WIDTH(8)) dut8 (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_val_i(val8),
    .msb_first_i(msb), .flush_i(flush), .deser_data_o(d8),
    .deser_mod_o(m8), .deser_data_val_o(v8), .busy_o(b8));

  deserializer_flex #(.WIDTH(32)) dut32 (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_val_i(val32),
    .msb_first_i(msb), .flush_i(flush), .deser_data_o(d32),
    .deser_mod_o(m32), .deser_data_val_o(v32), .busy_o(b32));

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_out(input int sel, output logic [63:0] d,
                         output logic [63:0] m, output logic v,
                         output logic b);
    if (sel == 8) begin
      d = 64'(d8); m = 64'(m8); v = v8; b = b8;
    end else if (sel == 32) begin
      d = 64'(d32); m = 64'(m32); v = v32; b = b32;
    end else begin
      d = 64'(d16); m = 64'(m16); v = v16; b = b16;
    end
  endtask

  task automatic idle();
    val16 = 1'b0; val8 = 1'b0; val32 = 1'b0; flush = 1'b0;
    step();
  endtask

  task automatic drive_bit(input int sel, input logic b, input logic m,
                           input logic f);
    data = b; msb = m; flush = f;
    val16 = (sel == 16); val8 = (sel == 8); val32 = (sel == 32);
    step();
    val16 = 1'b0; val8 = 1'b0; val32 = 1'b0; flush = 1'b0;
  endtask

  // Sends stream[0..n-1] back to back. msb_first_i is toggled on some later
  // bits of the word to show the order latched at the first bit is kept.
  task automatic send_word(input int sel, input logic [63:0] stream,
                           input int n, input logic m, input logic f_last,
                           input string tag);
    logic [63:0] od, om;
    logic        ov, ob;
    for (int k = 0; k < n; k++) begin
      drive_bit(sel, stream[k], (k > 0 && (k % 3) == 0) ? ~m : m,
                f_last && (k == n - 1));
      if (k < n - 1) begin
        get_out(sel, od, om, ov, ob);
        check($sformatf("%s_nopulse_%0d", tag, k), 64'(ov), 64'd0);
        check($sformatf("%s_busy_%0d", tag, k), 64'(ob), 64'd1);
      end
    end
  endtask

  task automatic expect_pulse(input int sel, input logic [63:0] exp_d,
                              input logic [63:0] exp_m, input string tag);
    logic [63:0] od, om;
    logic        ov, ob;
    get_out(sel, od, om, ov, ob);
    check({tag, "_val"},  64'(ov), 64'd1);
    check({tag, "_data"}, od, exp_d);
    check({tag, "_mod"},  om, exp_m);
    check({tag, "_busy"}, 64'(ob), 64'd0);
  endtask

  initial begin
    logic [31:0] gaps;
    int          acc;
    srst = 1'b1; data = 1'b0; msb = 1'b0; flush = 1'b0;
    val16 = 1'b0; val8 = 1'b0; val32 = 1'b0;
    step(); step();
    srst = 1'b0;
    check("rst_d16", 64'(d16), 64'd0);
    check("rst_m16", 64'(m16), 64'd0);
    check("rst_v16", 64'(v16), 64'd0);
    check("rst_b16", 64'(b16), 64'd0);
    check("rst_d32", 64'(d32), 64'd0);
    check("rst_v8",  64'(v8),  64'd0);

    // Alternating 1,0,1,0,... MSB-first, then LSB-first with no dead cycle.
    send_word(16, 64'h5555, 16, 1'b1, 1'b0, "msb16");
    expect_pulse(16, 64'hAAAA, 64'd16, "msb16");
    send_word(16, 64'h5555, 16, 1'b0, 1'b0, "lsb16");
    expect_pulse(16, 64'h5555, 64'd16, "lsb16");
    idle();
    check("hold_val",  64'(v16), 64'd0);
    check("hold_data", 64'(d16), 64'h5555);
    check("hold_mod",  64'(m16), 64'd16);

    // Sixteen ones with gaps in data_val.
    gaps = 32'h5A3C_96E2;
    acc  = 0;
    for (int i = 0; i < 64 && acc < 16; i++) begin
      if (gaps[i % 32]) begin
        idle();
        check($sformatf("gap_nopulse_%0d", i), 64'(v16), 64'd0);
        check($sformatf("gap_busy_%0d", i), 64'(b16), (acc > 0) ? 64'd1 : 64'd0);
      end else begin
        drive_bit(16, 1'b1, 1'b1, 1'b0);
        acc++;
        if (acc < 16) begin
          check($sformatf("gapbit_nopulse_%0d", i), 64'(v16), 64'd0);
          check($sformatf("gapbit_busy_%0d", i), 64'(b16), 64'd1);
        end
      end
    end
    expect_pulse(16, 64'hFFFF, 64'd16, "gapped");
    idle();

    // Partial words: 1,1,0,1,1 then flush alone.
    send_word(16, 64'h1B, 5, 1'b1, 1'b0, "pmsb");
    flush = 1'b1; step(); flush = 1'b0;
    expect_pulse(16, 64'hD800, 64'd5, "flush_msb");
    send_word(16, 64'h1B, 5, 1'b0, 1'b0, "plsb");
    flush = 1'b1; step(); flush = 1'b0;
    expect_pulse(16, 64'h001B, 64'd5, "flush_lsb");

    // Flush with nothing collected.
    idle();
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_empty_val",  64'(v16), 64'd0);
    check("flush_empty_busy", 64'(b16), 64'd0);

    // Flush together with the 16th bit: exactly one full-word pulse.
    send_word(16, 64'h0001, 16, 1'b1, 1'b1, "f16");
    expect_pulse(16, 64'h8000, 64'd16, "flush_full");
    idle();
    check("flush_full_once", 64'(v16), 64'd0);

    // Flush together with the 3rd bit: 1,0,1 MSB-first.
    send_word(16, 64'h5, 3, 1'b1, 1'b1, "f3");
    expect_pulse(16, 64'hA000, 64'd3, "flush_bit3");
    idle();

    // Reset mid-word, then a fresh word built only from post-reset bits.
    send_word(16, 64'h7F, 7, 1'b0, 1'b0, "pre16");
    srst = 1'b1; step(); srst = 1'b0;
    check("mid_rst_val",  64'(v16), 64'd0);
    check("mid_rst_busy", 64'(b16), 64'd0);
    check("mid_rst_data", 64'(d16), 64'd0);
    check("mid_rst_mod",  64'(m16), 64'd0);
    send_word(16, 64'h00C3, 16, 1'b1, 1'b0, "post16");
    expect_pulse(16, 64'hC300, 64'd16, "post_rst16");
    idle();

    // WIDTH=8: reset mid-word, then LSB and MSB words.
    send_word(8, 64'h1F, 5, 1'b1, 1'b0, "pre8");
    srst = 1'b1; step(); srst = 1'b0;
    check("rst8_busy", 64'(b8), 64'd0);
    send_word(8, 64'hA5, 8, 1'b0, 1'b0, "w8lsb");
    expect_pulse(8, 64'hA5, 64'd8, "w8_lsb");
    send_word(8, 64'h85, 8, 1'b1, 1'b0, "w8msb");
    expect_pulse(8, 64'hA1, 64'd8, "w8_msb");
    idle();

    // WIDTH=32: reset mid-word, full MSB word, then an LSB partial flush.
    send_word(32, 64'h7F, 7, 1'b0, 1'b0, "pre32");
    srst = 1'b1; step(); srst = 1'b0;
    check("rst32_busy", 64'(b32), 64'd0);
    send_word(32, 64'h8000_0003, 32, 1'b1, 1'b0, "w32");
    expect_pulse(32, 64'hC000_0001, 64'd32, "w32_msb");
    send_word(32, 64'h5, 3, 1'b0, 1'b0, "p32");
    flush = 1'b1; step(); flush = 1'b0;
    expect_pulse(32, 64'h5, 64'd3, "w32_flush");
    idle();
    check("w16_quiet", 64'(v16), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
